// File: rtl/flush_arbiter.sv
// flush_arbiter: grants the shared downlink to one of two scanners, drives its flush, waits for drain, accumulates units
module flush_arbiter #(
  parameter logic [2:0] FLUSH_ST = 3'b100,
  parameter int TIMEOUT = 16,
  parameter int TOT_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic link_ok,
  input  logic rdy_flush1,
  input  logic rdy_flush2,
  input  logic [7:0] mem_used1,
  input  logic [7:0] mem_used2,
  input  logic [2:0] state1,
  input  logic [2:0] state2,
  output logic flush1,
  output logic flush2,
  output logic busy,
  output logic sel,
  output logic xfer_done,
  output logic timeout_err,
  output logic [TOT_W-1:0] total_xferred
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic sel_q, sel_d, last_q, last_d, to_q, to_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] lvl_q, lvl_d;
  logic [TOT_W-1:0] tot_q, tot_d;
  logic [TOT_W:0] sum;
  logic in_flush;
  logic [7:0] mem_sel;
  assign in_flush = (sel_q ? state2 : state1) == FLUSH_ST;
  assign mem_sel = sel_q ? mem_used2 : mem_used1;
  assign sum = {1'b0, tot_q} + (TOT_W + 1)'(lvl_q);
  // next-state: selection in IDLE, flush handshake/timeout in GRANT, drain wait, saturating accumulate in DONE
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    last_d = last_q;
    cnt_d = '0;
    lvl_d = lvl_q;
    tot_d = tot_q;
    to_d = 1'b0;
    case (state_q)
      IDLE: if (link_ok && (rdy_flush1 || rdy_flush2)) begin
        state_d = GRANT;
        sel_d = rdy_flush2 && (!rdy_flush1 || !last_q);
      end
      GRANT: begin
        cnt_d = cnt_q + CW'(1);
        if (in_flush) begin
          lvl_d = mem_sel;
          state_d = DRAIN;
        end else if (!link_ok) state_d = IDLE;
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          to_d = 1'b1;
        end
      end
      DRAIN: if (mem_sel == 8'd0 && !in_flush) state_d = DONE;
      DONE: begin
        tot_d = sum[TOT_W] ? '1 : sum[TOT_W-1:0];
        last_d = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register; last_served starts at scanner 2 so scanner 1 wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q <= 1'b0;
      last_q <= 1'b1;
      to_q <= 1'b0;
      cnt_q <= '0;
      lvl_q <= '0;
      tot_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      last_q <= last_d;
      to_q <= to_d;
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      tot_q <= tot_d;
    end
  end
  assign busy = state_q != IDLE;
  assign flush1 = state_q == GRANT && !sel_q;
  assign flush2 = state_q == GRANT && sel_q;
  assign sel = sel_q;
  assign xfer_done = state_q == DONE;
  assign timeout_err = to_q;
  assign total_xferred = tot_q;
endmodule
